ac_match_engine: RTL and testbench
==================================

// Module: ac_match_engine
// PURPOSE
//  Parametrised Aho-Corasick streaming matcher. It merges goto, failure and output tables into one engine.
//  The tables are host-loadable through a config write port. Characters arrive on a valid/ready stream.
//  For each character the engine follows failure links until a goto hit occurs, then reports a match (id, position).
//  Successor to the fixed 8-bit-state / 4-bit-char goto+failure datapath.
// PARAMETERS
//  STATE_W   8   state index width; 2**STATE_W states, state 0 = root
//  CHAR_W    4   character width
//  ID_W      8   pattern id width
//  POS_W     16  stream position counter width
//  MAX_FAIL  255 fail-chain step limit (used only with AC_LOOP_GUARD_EN)
// PORTS
//  CLK         in   1                 clock, rising edge
//  RST         in   1                 synchronous reset, active-low
//  CFG_WE      in   1                 table write strobe
//  CFG_SEL     in   2                 table select: 0 goto, 1 failure, 2 output, 3 reserved (write dropped)
//  CFG_ADDR    in   STATE_W+CHAR_W    goto: {state,char}; failure/output: state in LSBs
//  CFG_DATA    in   STATE_W+1 / ID_W+1  goto {valid,next}; fail {-,fstate}; out {match,id} (LSB-aligned)
//  IN_VALID    in   1                 character valid
//  IN_READY    out  1                 engine can accept a character
//  IN_CHAR     in   CHAR_W            character
//  IN_LAST     in   1                 last character of the message
//  MATCH_VALID out  1                 one-cycle match pulse
//  MATCH_ID    out  ID_W              pattern id of the match
//  MATCH_POS   out  POS_W             0-based position of the char ending the match
//  DONE        out  1                 one-cycle pulse after the IN_LAST char is fully processed
//  ERR         out  1                 sticky fail-chain overflow (tied 0 without AC_LOOP_GUARD_EN)
// BEHAVIOUR
//  Reset (RST==0 at an edge)
//   - outputs: MATCH_VALID=0, MATCH_ID=0, MATCH_POS=0, DONE=0, ERR=0.
//   - engine state: cur=0, pos=0, FSM=S_IDLE; IN_READY=0 while RST==0.
//   - table contents are NOT cleared; reset mid-message aborts it with no MATCH/DONE.
//  Tables: synchronous-read RAMs, 1-cycle read latency, written only via CFG port.
//  IN_READY = (FSM==S_IDLE) & ~CFG_WE.
//   - Accept on IN_VALID&IN_READY: latch char and last, issue goto read {cur,char}, go S_GOTO.
//  CFG_WE: performed only in S_IDLE. It wins over IN_VALID (char not accepted that cycle); ignored in other states.
//  S_GOTO (goto data valid):
//   - hit (valid=1): cur<=next, issue output read, go S_EMIT.
//   - miss, cur==0: cur<=0, issue output read, go S_EMIT (root self-loop).
//   - miss, cur!=0: issue failure read [cur], go S_FAIL.
//  S_FAIL: cur<=fail data, issue goto read {fail data,char}, go S_GOTO.
//  S_EMIT:
//   - if out.match: next cycle MATCH_VALID=1, MATCH_ID=out.id, MATCH_POS=pos.
//   - pos<=pos+1, wrapping modulo 2**POS_W.
//   - if latched last: next cycle DONE=1, cur<=0, pos<=0 (MATCH reported same cycle as DONE).
//   - go S_IDLE.
//  Output table holds merged (deepest) id per state; one match per char max.
//  Latency:
//   - no failure: accept edge E -> MATCH_VALID/DONE high in the cycle after the 3rd edge (IDLE,GOTO,EMIT).
//   - each failure step adds 2 cycles; throughput 1 char/3 cycles best case.
//  MATCH_VALID, DONE are single-cycle pulses; no backpressure on outputs.
// CONFIGURATION
//  AC_LOOP_GUARD_EN defined:
//   - fail-step counter cleared on accept, +1 per S_FAIL entry.
//   - reaching MAX_FAIL at S_GOTO miss forces cur<=0, goes S_EMIT using output[0], sets ERR sticky until reset.
//  AC_LOOP_GUARD_EN undefined:
//   - no counter; a cyclic failure table may hang the engine (IN_READY stays 0); ERR=0.
// TESTING
//  Direct hit:
//   - load goto{0,1}->1, goto{1,2}->2, out[2]={1,5}; stream 1,2(last)
//   - -> MATCH_VALID once, ID=5, POS=1; DONE same cycle.
//  Failure walk:
//   - patterns [1,2,3]->id1, [2,4]->id2, fail[2]=state([2]); stream 1,2,4
//   - -> one match ID=2 POS=2, 2 extra cycles on char 4.
//  Root miss: empty table, stream 7 x 10 chars -> no MATCH, IN_READY every 3rd cycle, DONE after last, POS wraps test with POS_W=3.
//  Config collision:
//   - CFG_WE and IN_VALID same IDLE cycle -> write lands, IN_READY=0, char accepted next cycle.
//   - CFG_WE in S_GOTO -> RAM unchanged.
//  Reset mid-op: RST=0 in S_FAIL -> next cycle IN_READY=0, outputs 0; after release cur=0, tables retained, rerun test 1 passes.
//  Loop guard (macro on, MAX_FAIL=3): fail[1]=2, fail[2]=1, both goto-miss -> ERR=1, engine returns to S_IDLE, DONE on last.

Source files
------------

// File: rtl/ac_match_engine.sv
// Aho-Corasick streaming matcher with host-loadable goto, failure and output tables.
// Optional fail-chain loop guard is enabled by defining AC_LOOP_GUARD_EN.
module ac_match_engine #(
    parameter int STATE_W  = 8,
    parameter int CHAR_W   = 4,
    parameter int ID_W     = 8,
    parameter int POS_W    = 16,
    parameter int MAX_FAIL = 255,
    parameter int DATA_W   = ((STATE_W > ID_W) ? STATE_W : ID_W) + 1
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      CFG_WE,
    input  logic [1:0]                CFG_SEL,
    input  logic [STATE_W+CHAR_W-1:0] CFG_ADDR,
    input  logic [DATA_W-1:0]         CFG_DATA,
    input  logic                      IN_VALID,
    output logic                      IN_READY,
    input  logic [CHAR_W-1:0]         IN_CHAR,
    input  logic                      IN_LAST,
    output logic                      MATCH_VALID,
    output logic [ID_W-1:0]           MATCH_ID,
    output logic [POS_W-1:0]          MATCH_POS,
    output logic                      DONE,
    output logic                      ERR
);

    localparam int GA_W = STATE_W + CHAR_W;

    typedef enum logic [1:0] {S_IDLE, S_GOTO, S_FAIL, S_EMIT} state_t;

    logic [STATE_W:0]   goto_mem [2**GA_W];
    logic [STATE_W-1:0] fail_mem [2**STATE_W];
    logic [ID_W:0]      out_mem  [2**STATE_W];

    logic [STATE_W:0]   goto_rd_q;
    logic [STATE_W-1:0] fail_rd_q;
    logic [ID_W:0]      out_rd_q;

    logic [GA_W-1:0]    goto_raddr;
    logic [STATE_W-1:0] fail_raddr;
    logic [STATE_W-1:0] out_raddr;

    state_t             state_q, state_d;
    logic [STATE_W-1:0] cur_q, cur_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    logic [CHAR_W-1:0]  char_q, char_d;
    logic               last_q, last_d;
    logic               match_valid_q, match_valid_d;
    logic [ID_W-1:0]    match_id_q, match_id_d;
    logic [POS_W-1:0]   match_pos_q, match_pos_d;
    logic               done_q, done_d;

    logic               cfg_en;
    logic               accept;
    logic               goto_hit;
    logic [STATE_W-1:0] goto_next;

`ifdef AC_LOOP_GUARD_EN
    localparam int FCNT_W = $clog2(MAX_FAIL + 1);
    logic [FCNT_W-1:0]  fail_cnt_q, fail_cnt_d;
    logic               err_q, err_d;
`else
    logic               unused_max_fail;
    assign unused_max_fail = (MAX_FAIL == 0);
`endif

    assign cfg_en    = CFG_WE && (state_q == S_IDLE);
    assign IN_READY  = RST && (state_q == S_IDLE) && !CFG_WE;
    assign accept    = IN_VALID && IN_READY;
    assign goto_hit  = goto_rd_q[STATE_W];
    assign goto_next = goto_rd_q[STATE_W-1:0];

    // Tables keep their contents through reset; select 3 writes are dropped.
    always_ff @(posedge CLK) begin
        if (cfg_en && (CFG_SEL == 2'd0)) goto_mem[CFG_ADDR] <= CFG_DATA[STATE_W:0];
        if (cfg_en && (CFG_SEL == 2'd1)) fail_mem[CFG_ADDR[STATE_W-1:0]] <= CFG_DATA[STATE_W-1:0];
        if (cfg_en && (CFG_SEL == 2'd2)) out_mem[CFG_ADDR[STATE_W-1:0]] <= CFG_DATA[ID_W:0];
        goto_rd_q <= goto_mem[goto_raddr];
        fail_rd_q <= fail_mem[fail_raddr];
        out_rd_q  <= out_mem[out_raddr];
    end

    always_comb begin
        state_d       = state_q;
        cur_d         = cur_q;
        pos_d         = pos_q;
        char_d        = char_q;
        last_d        = last_q;
        match_valid_d = 1'b0;
        match_id_d    = match_id_q;
        match_pos_d   = match_pos_q;
        done_d        = 1'b0;
        goto_raddr    = {cur_q, IN_CHAR};
        fail_raddr    = cur_q;
        out_raddr     = goto_next;
`ifdef AC_LOOP_GUARD_EN
        fail_cnt_d    = fail_cnt_q;
        err_d         = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    char_d  = IN_CHAR;
                    last_d  = IN_LAST;
                    state_d = S_GOTO;
`ifdef AC_LOOP_GUARD_EN
                    fail_cnt_d = '0;
`endif
                end
            end
            S_GOTO: begin
                if (goto_hit) begin
                    cur_d     = goto_next;
                    out_raddr = goto_next;
                    state_d   = S_EMIT;
                end else if (cur_q == '0) begin
                    out_raddr = '0;
                    state_d   = S_EMIT;
                end else begin
`ifdef AC_LOOP_GUARD_EN
                    // A fail chain this long is assumed cyclic: bail out to the root.
                    if (fail_cnt_q >= FCNT_W'(MAX_FAIL)) begin
                        cur_d     = '0;
                        out_raddr = '0;
                        err_d     = 1'b1;
                        state_d   = S_EMIT;
                    end else begin
                        fail_raddr = cur_q;
                        fail_cnt_d = fail_cnt_q + FCNT_W'(1);
                        state_d    = S_FAIL;
                    end
`else
                    fail_raddr = cur_q;
                    state_d    = S_FAIL;
`endif
                end
            end
            S_FAIL: begin
                cur_d      = fail_rd_q;
                goto_raddr = {fail_rd_q, char_q};
                state_d    = S_GOTO;
            end
            S_EMIT: begin
                if (out_rd_q[ID_W]) begin
                    match_valid_d = 1'b1;
                    match_id_d    = out_rd_q[ID_W-1:0];
                    match_pos_d   = pos_q;
                end
                if (last_q) begin
                    done_d = 1'b1;
                    cur_d  = '0;
                    pos_d  = '0;
                end else begin
                    pos_d = pos_q + POS_W'(1);
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q       <= S_IDLE;
            cur_q         <= '0;
            pos_q         <= '0;
            char_q        <= '0;
            last_q        <= 1'b0;
            match_valid_q <= 1'b0;
            match_id_q    <= '0;
            match_pos_q   <= '0;
            done_q        <= 1'b0;
`ifdef AC_LOOP_GUARD_EN
            fail_cnt_q    <= '0;
            err_q         <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            cur_q         <= cur_d;
            pos_q         <= pos_d;
            char_q        <= char_d;
            last_q        <= last_d;
            match_valid_q <= match_valid_d;
            match_id_q    <= match_id_d;
            match_pos_q   <= match_pos_d;
            done_q        <= done_d;
`ifdef AC_LOOP_GUARD_EN
            fail_cnt_q    <= fail_cnt_d;
            err_q         <= err_d;
`endif
        end
    end

    assign MATCH_VALID = match_valid_q;
    assign MATCH_ID    = match_id_q;
    assign MATCH_POS   = match_pos_q;
    assign DONE        = done_q;
`ifdef AC_LOOP_GUARD_EN
    assign ERR         = err_q;
`else
    assign ERR         = 1'b0;
`endif

endmodule

// File: tb/tb_ac_match_engine.sv
// Directed bench for ac_match_engine: hit, failure walk, root miss with position wrap,
// config collisions, mid-operation reset and (with AC_LOOP_GUARD_EN) the loop guard.
module tb_ac_match_engine;

    localparam int STATE_W  = 8;
    localparam int CHAR_W   = 4;
    localparam int ID_W     = 8;
    localparam int POS_W    = 3;
    localparam int MAX_FAIL = 3;
    localparam int DATA_W   = 9;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      cfg_we = 1'b0;
    logic [1:0]                cfg_sel = '0;
    logic [STATE_W+CHAR_W-1:0] cfg_addr = '0;
    logic [DATA_W-1:0]         cfg_data = '0;
    logic                      in_valid = 1'b0;
    logic                      in_ready;
    logic [CHAR_W-1:0]         in_char = '0;
    logic                      in_last = 1'b0;
    logic                      match_valid;
    logic [ID_W-1:0]           match_id;
    logic [POS_W-1:0]          match_pos;
    logic                      done;
    logic                      err;

    int total = 0;
    int bad = 0;
    int match_cnt = 0;
    int done_cnt = 0;

    ac_match_engine #(
        .STATE_W (STATE_W),
        .CHAR_W  (CHAR_W),
        .ID_W    (ID_W),
        .POS_W   (POS_W),
        .MAX_FAIL(MAX_FAIL),
        .DATA_W  (DATA_W)
    ) dut (
        .CLK        (clk),
        .RST        (rst_n),
        .CFG_WE     (cfg_we),
        .CFG_SEL    (cfg_sel),
        .CFG_ADDR   (cfg_addr),
        .CFG_DATA   (cfg_data),
        .IN_VALID   (in_valid),
        .IN_READY   (in_ready),
        .IN_CHAR    (in_char),
        .IN_LAST    (in_last),
        .MATCH_VALID(match_valid),
        .MATCH_ID   (match_id),
        .MATCH_POS  (match_pos),
        .DONE       (done),
        .ERR        (err)
    );

    always #5 clk = ~clk;

    // Pulse counters catch stray or duplicated MATCH/DONE pulses between directed checks.
    always @(negedge clk) begin
        if (match_valid === 1'b1) match_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [11:0] addr, input logic [8:0] data);
        cfg_we   = 1'b1;
        cfg_sel  = sel;
        cfg_addr = addr;
        cfg_data = data;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic clear_tables();
        for (int a = 0; a < 4096; a++) cfg_write(2'd0, 12'(a), 9'd0);
        for (int a = 0; a < 256; a++) cfg_write(2'd1, 12'(a), 9'd0);
        for (int a = 0; a < 256; a++) cfg_write(2'd2, 12'(a), 9'd0);
    endtask

    // Returns right after the accepting edge (state is S_GOTO).
    task automatic send_char(input logic [3:0] c, input logic last);
        int w;
        w = 0;
        while (in_ready !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("[TB] FAIL ready_timeout: in_ready=%b, wanted 1 within 40 cycles", in_ready);
        end
        in_valid = 1'b1;
        in_char  = c;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rst_ready: got %b want 0", in_ready); end
        total++; if (match_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_mv: got %b want 0", match_valid); end
        total++; if (match_id !== 8'd0) begin bad++; $display("[TB] FAIL rst_id: got %h want 00", match_id); end
        total++; if (match_pos !== 3'd0) begin bad++; $display("[TB] FAIL rst_pos: got %0d want 0", match_pos); end
        total++; if (done !== 1'b0) begin bad++; $display("[TB] FAIL rst_done: got %b want 0", done); end
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL rst_err: got %b want 0", err); end
        rst_n = 1'b1;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_release_ready: got %b want 1", in_ready); end
    endtask

    task automatic test_direct_hit();
        int m0, d0;
        cfg_write(2'd0, 12'h001, 9'h101);
        cfg_write(2'd0, 12'h012, 9'h102);
        cfg_write(2'd2, 12'h002, 9'h105);
        m0 = match_cnt;
        d0 = done_cnt;
        send_char(4'd1, 1'b0);
        tick();
        tick();
        total++; if (match_valid !== 1'b0) begin bad++; $display("[TB] FAIL hit_c1_mv: got %b want 0", match_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL hit_c1_ready: got %b want 1", in_ready); end
        send_char(4'd2, 1'b1);
        tick();
        total++; if (match_valid !== 1'b0) begin bad++; $display("[TB] FAIL hit_early_mv: got %b want 0", match_valid); end
        tick();
        total++; if (match_valid !== 1'b1) begin bad++; $display("[TB] FAIL hit_mv: got %b want 1", match_valid); end
        total++; if (match_id !== 8'd5) begin bad++; $display("[TB] FAIL hit_id: got %0d want 5", match_id); end
        total++; if (match_pos !== 3'd1) begin bad++; $display("[TB] FAIL hit_pos: got %0d want 1", match_pos); end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL hit_done: got %b want 1", done); end
        tick();
        total++; if (match_valid !== 1'b0 || done !== 1'b0) begin
            bad++; $display("[TB] FAIL hit_pulse: mv=%b done=%b want 0 0", match_valid, done);
        end
        total++; if (match_cnt - m0 != 1 || done_cnt - d0 != 1) begin
            bad++; $display("[TB] FAIL hit_counts: matches=%0d dones=%0d want 1 1", match_cnt - m0, done_cnt - d0);
        end
    endtask

    task automatic test_failure_walk();
        int m0;
        cfg_write(2'd2, 12'h002, 9'h000);
        cfg_write(2'd0, 12'h023, 9'h103);
        cfg_write(2'd2, 12'h003, 9'h101);
        cfg_write(2'd0, 12'h002, 9'h104);
        cfg_write(2'd0, 12'h044, 9'h105);
        cfg_write(2'd2, 12'h005, 9'h102);
        cfg_write(2'd1, 12'h002, 9'h004);
        m0 = match_cnt;
        send_char(4'd1, 1'b0);
        tick();
        tick();
        send_char(4'd2, 1'b0);
        tick();
        tick();
        total++; if (match_valid !== 1'b0) begin bad++; $display("[TB] FAIL fw_c2_mv: got %b want 0", match_valid); end
        send_char(4'd4, 1'b1);
        tick();
        tick();
        total++; if (match_valid !== 1'b0 || in_ready !== 1'b0) begin
            bad++; $display("[TB] FAIL fw_extra_cycles: mv=%b ready=%b want 0 0", match_valid, in_ready);
        end
        tick();
        tick();
        total++; if (match_valid !== 1'b1) begin bad++; $display("[TB] FAIL fw_mv: got %b want 1", match_valid); end
        total++; if (match_id !== 8'd2) begin bad++; $display("[TB] FAIL fw_id: got %0d want 2", match_id); end
        total++; if (match_pos !== 3'd2) begin bad++; $display("[TB] FAIL fw_pos: got %0d want 2", match_pos); end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL fw_done: got %b want 1", done); end
        tick();
        total++; if (match_cnt - m0 != 1) begin bad++; $display("[TB] FAIL fw_count: got %0d want 1", match_cnt - m0); end
    endtask

    task automatic test_root_miss();
        int m0;
        m0 = match_cnt;
        for (int i = 0; i < 10; i++) begin
            send_char(4'd7, (i == 9));
            total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL rm_busy[%0d]: got %b want 0", i, in_ready); end
            tick();
            tick();
            total++; if (in_ready !== 1'b1 || done !== (i == 9)) begin
                bad++; $display("[TB] FAIL rm_step[%0d]: ready=%b done=%b want 1 %b", i, in_ready, done, (i == 9));
            end
        end
        total++; if (match_cnt != m0) begin bad++; $display("[TB] FAIL rm_nomatch: got %0d want 0", match_cnt - m0); end
        cfg_write(2'd2, 12'h000, 9'h109);
        for (int i = 0; i < 10; i++) begin
            send_char(4'd7, (i == 9));
            tick();
            tick();
            total++; if (match_valid !== 1'b1 || match_id !== 8'h09 || match_pos !== 3'(i)) begin
                bad++; $display("[TB] FAIL rm_wrap[%0d]: mv=%b id=%h pos=%0d want 1 09 %0d", i, match_valid, match_id, match_pos, i % 8);
            end
        end
        cfg_write(2'd2, 12'h000, 9'h000);
    endtask

    task automatic test_cfg_collision();
        cfg_write(2'd2, 12'h006, 9'h133);
        cfg_we   = 1'b1;
        cfg_sel  = 2'd0;
        cfg_addr = 12'h003;
        cfg_data = 9'h106;
        in_valid = 1'b1;
        in_char  = 4'd3;
        in_last  = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL col_ready_we: got %b want 0", in_ready); end
        tick();
        cfg_we = 1'b0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL col_ready_after: got %b want 1", in_ready); end
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL col_accepted: ready=%b want 0", in_ready); end
        cfg_we   = 1'b1;
        cfg_sel  = 2'd2;
        cfg_addr = 12'h006;
        cfg_data = 9'h000;
        tick();
        cfg_we = 1'b0;
        tick();
        total++; if (match_valid !== 1'b1 || match_id !== 8'h33 || match_pos !== 3'd0 || done !== 1'b1) begin
            bad++; $display("[TB] FAIL col_match: mv=%b id=%h pos=%0d done=%b want 1 33 0 1", match_valid, match_id, match_pos, done);
        end
        send_char(4'd3, 1'b1);
        tick();
        tick();
        total++; if (match_valid !== 1'b1 || match_id !== 8'h33) begin
            bad++; $display("[TB] FAIL col_busy_write_dropped: mv=%b id=%h want 1 33", match_valid, match_id);
        end
    endtask

    task automatic test_reset_midop();
        int m0, d0;
        cfg_write(2'd2, 12'h002, 9'h105);
        send_char(4'd1, 1'b0);
        tick();
        tick();
        m0 = match_cnt;
        d0 = done_cnt;
        send_char(4'd5, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL mid_ready: got %b want 0", in_ready); end
        total++; if (match_valid !== 1'b0 || match_id !== 8'd0 || match_pos !== 3'd0 || done !== 1'b0) begin
            bad++; $display("[TB] FAIL mid_outputs: mv=%b id=%h pos=%0d done=%b want 0 00 0 0", match_valid, match_id, match_pos, done);
        end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        total++; if (match_cnt != m0 || done_cnt != d0) begin
            bad++; $display("[TB] FAIL mid_abort: matches=%0d dones=%0d want 0 0", match_cnt - m0, done_cnt - d0);
        end
        send_char(4'd1, 1'b0);
        tick();
        tick();
        send_char(4'd2, 1'b1);
        tick();
        tick();
        total++; if (match_valid !== 1'b1 || match_id !== 8'd5 || match_pos !== 3'd1 || done !== 1'b1) begin
            bad++; $display("[TB] FAIL mid_rerun: mv=%b id=%0d pos=%0d done=%b want 1 5 1 1", match_valid, match_id, match_pos, done);
        end
`ifndef AC_LOOP_GUARD_EN
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL err_tied: got %b want 0", err); end
`endif
    endtask

`ifdef AC_LOOP_GUARD_EN
    task automatic test_loop_guard();
        int w;
        cfg_write(2'd1, 12'h001, 9'h002);
        cfg_write(2'd1, 12'h002, 9'h001);
        send_char(4'd1, 1'b0);
        tick();
        tick();
        total++; if (err !== 1'b0) begin bad++; $display("[TB] FAIL lg_err_before: got %b want 0", err); end
        send_char(4'd9, 1'b1);
        w = 0;
        while (done !== 1'b1 && w < 40) begin
            tick();
            w++;
        end
        total++; if (done !== 1'b1) begin bad++; $display("[TB] FAIL lg_done: got %b want 1 within 40 cycles", done); end
        total++; if (err !== 1'b1 || match_valid !== 1'b0) begin
            bad++; $display("[TB] FAIL lg_err: err=%b mv=%b want 1 0", err, match_valid);
        end
        tick();
        tick();
        total++; if (err !== 1'b1 || in_ready !== 1'b1) begin
            bad++; $display("[TB] FAIL lg_sticky: err=%b ready=%b want 1 1", err, in_ready);
        end
    endtask
`endif

    initial begin
        test_reset();
        clear_tables();
        test_direct_hit();
        test_failure_walk();
        test_root_miss();
        test_cfg_collision();
        test_reset_midop();
`ifdef AC_LOOP_GUARD_EN
        test_loop_guard();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
